key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//  Front-end for the menu keys: replaces the four per-key debouncers ahead of top.
//  Synchronises the raw active-low KEY[3:0] pins into the audio bit clock and debounces them.
//  Emits one-cycle press/release strobes and an auto-repeat strobe train on held keys.
//  o_press[3:0] drives top's i_select/i_back/i_up/i_down.
// PARAMETERS
//  N_KEYS         4       number of independent key channels
//  DEB_CYCLES     4096    consecutive stable samples required to accept a level change (>=2)
//  REPEAT_DELAY   600000  cycles from press strobe to first repeat strobe (>=2)
//  REPEAT_PERIOD  150000  cycles between subsequent repeat strobes (>=2)
//  REPEAT_MASK    4'b0011 per-key repeat enable; default repeats up/down only
// PORTS
//  i_clk      in   1       AUD_BCLK domain clock
//  i_rst_n    in   1       synchronous reset, active-low
//  i_key_n    in   N_KEYS  raw asynchronous key pins, 0 = pressed
//  o_press    out  N_KEYS  1-cycle strobe: accepted press, or repeat tick while held
//  o_release  out  N_KEYS  1-cycle strobe: accepted release
//  o_held     out  N_KEYS  level: key debounced-pressed
// BEHAVIOUR
//  Reset: i_clk and i_rst_n only; reset is synchronous and active-low. While i_rst_n=0 at an edge:
//   - all outputs 0; all channels KS_IDLE; counters 0
//   - sync flops preset to 1 (released)
//  Channels are fully independent; simultaneous activity on several keys is legal and needs no arbitration.
//  Per channel: 2-flop synchroniser -> FSM with debounce counter dcnt and repeat counter rcnt. All outputs registered.
//  FSM (s = synchronised level):
//   - KS_IDLE: s=0 -> KS_DEB_DN, dcnt=0.
//   - KS_DEB_DN: s=1 -> KS_IDLE (bounce, no strobe). Else dcnt++.
//     At dcnt==DEB_CYCLES-1 -> KS_HELD, o_press=1 for 1 cycle, rcnt=0.
//   - KS_HELD: s=1 -> KS_DEB_UP, dcnt=0. Else rcnt++.
//     If repeat enabled for this key and rcnt==REPEAT_DELAY-1 -> KS_REPEAT, o_press=1, rcnt=0.
//   - KS_REPEAT: s=1 -> KS_DEB_UP, dcnt=0. Else rcnt++.
//     At rcnt==REPEAT_PERIOD-1 -> o_press=1, rcnt=0 (wraps, unbounded train).
//   - KS_DEB_UP: s=0 -> KS_HELD, rcnt=0 (release bounce; no strobe; repeat restarts from REPEAT_DELAY).
//     Else dcnt++; at dcnt==DEB_CYCLES-1 -> KS_IDLE, o_release=1 for 1 cycle.
//  o_held = 1 in KS_HELD, KS_REPEAT, KS_DEB_UP; updates on the same edge as the strobes.
//  Latency: raw stable 0 -> o_press high after the (DEB_CYCLES+3)th rising edge. Release is symmetric for o_release.
//  First repeat strobe comes REPEAT_DELAY cycles after the press strobe; later strobes every REPEAT_PERIOD cycles.
//  o_press and o_release are never both 1 on one channel.
//  Counter widths: $clog2(max of DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1; counters saturate-free by construction.
//  Reset mid-operation: channel returns to KS_IDLE with no release strobe.
//   A key held through reset deassertion is re-debounced and yields one press strobe.
// CONFIGURATION
//  KEY_REPEAT_EN defined:
//   - auto-repeat as above, gated per key by REPEAT_MASK.
//  KEY_REPEAT_EN undefined:
//   - KS_REPEAT and rcnt are not built; KS_HELD only waits for release.
//   - REPEAT_DELAY, REPEAT_PERIOD and REPEAT_MASK are ignored.
//   - exactly one o_press strobe per physical press.
// STRUCTURE
//  key_pkg: typedef enum logic [2:0] key_state_e {KS_IDLE, KS_DEB_DN, KS_HELD, KS_REPEAT, KS_DEB_UP};
//   also the key index constants KEY_DOWN=0, KEY_UP=1, KEY_BACK=2, KEY_SELECT=3.
//  Sub-module key_channel: one synchroniser + FSM + counters.
//   key_conditioner is a generate loop of N_KEYS key_channel instances plus the REPEAT_MASK bit select.
// TESTING (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; KEY_REPEAT_EN on unless stated)
//  1. Clean press: key0 0 held 100 cycles -> o_press[0] single pulse on 7th edge.
//     o_held[0] rises with it; repeat pulses 20 cycles later, then every 8.
//  2. Press bounce: key1 toggles 0/1 every 2 cycles for 20 cycles then stays 1 -> no strobes, o_held[1]=0 throughout.
//  3. Release bounce: key0 held, 2-cycle high glitch -> no o_release.
//     Repeat timer restarts: next o_press 20 cycles after re-entry to KS_HELD.
//  4. Non-repeat key: key3 held 100 cycles -> exactly one o_press[3].
//     On release, o_release[3] on 7th edge after pin goes 1.
//  5. Simultaneous: keys 0 and 2 pressed same cycle -> o_press[0] and o_press[2] pulse on the same edge.
//     Channels 1 and 3 stay quiet.
//  6. Reset mid-hold: i_rst_n=0 for 3 cycles while key1 is in KS_REPEAT -> all outputs 0, no o_release.
//     After deassertion with key still held, one o_press[1] on 7th edge.
//     Build with KEY_REPEAT_EN undefined: scenario 1 gives exactly one pulse.

Source files
------------

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key channel state encoding, key index constants and sizing helper.
package key_pkg;

    typedef enum logic [2:0] {
        KS_IDLE,
        KS_DEB_DN,
        KS_HELD,
        KS_REPEAT,
        KS_DEB_UP
    } key_state_e;

    localparam int KEY_DOWN   = 0;
    localparam int KEY_UP     = 1;
    localparam int KEY_BACK   = 2;
    localparam int KEY_SELECT = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: 2-flop synchroniser, debounce FSM, optional auto-repeat (KEY_REPEAT_EN).
module key_channel
    import key_pkg::*;
#(
    parameter int DEB_CYCLES    = 4096,
    parameter int REPEAT_DELAY  = 600000,
    parameter int REPEAT_PERIOD = 150000,
    parameter bit REP_EN        = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press,
    output logic o_release,
    output logic o_held
);

    localparam int CW = $clog2(max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] r_rcnt;
`endif

    logic          r_sync1;
    logic          r_sync2;
    key_state_e    r_state;
    logic [CW-1:0] r_dcnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= KS_IDLE;
            r_dcnt    <= '0;
`ifdef KEY_REPEAT_EN
            r_rcnt    <= '0;
`endif
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_held    <= 1'b0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            case (r_state)
                KS_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= KS_DEB_DN;
                        r_dcnt  <= '0;
                    end
                end
                KS_DEB_DN: begin
                    if (r_sync2) begin
                        r_state <= KS_IDLE;
                    end else if (r_dcnt == DEB_LAST) begin
                        r_state <= KS_HELD;
                        o_press <= 1'b1;
                        o_held  <= 1'b1;
`ifdef KEY_REPEAT_EN
                        r_rcnt  <= '0;
`endif
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                KS_HELD: begin
                    if (r_sync2) begin
                        r_state <= KS_DEB_UP;
                        r_dcnt  <= '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (REP_EN && r_rcnt == RD_LAST) begin
                        r_state <= KS_REPEAT;
                        o_press <= 1'b1;
                        r_rcnt  <= '0;
                    end else if (REP_EN) begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
`endif
                end
`ifdef KEY_REPEAT_EN
                KS_REPEAT: begin
                    if (r_sync2) begin
                        r_state <= KS_DEB_UP;
                        r_dcnt  <= '0;
                    end else if (r_rcnt == RP_LAST) begin
                        o_press <= 1'b1;
                        r_rcnt  <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
`endif
                KS_DEB_UP: begin
                    // A low sample here is release bounce: back to held, repeat delay starts over.
                    if (!r_sync2) begin
                        r_state <= KS_HELD;
`ifdef KEY_REPEAT_EN
                        r_rcnt  <= '0;
`endif
                    end else if (r_dcnt == DEB_LAST) begin
                        r_state   <= KS_IDLE;
                        o_release <= 1'b1;
                        o_held    <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= KS_IDLE;
                    o_held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N_KEYS independent key channels; auto-repeat built only with KEY_REPEAT_EN.
module key_conditioner
    import key_pkg::*;
#(
    parameter int                N_KEYS        = 4,
    parameter int                DEB_CYCLES    = 4096,
    parameter int                REPEAT_DELAY  = 600000,
    parameter int                REPEAT_PERIOD = 150000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK   = 'b0011
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_held
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_channel #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REP_EN       (REPEAT_MASK[g])
        ) u_channel (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_key_n  (i_key_n[g]),
            .o_press  (o_press[g]),
            .o_release(o_release[g]),
            .o_held   (o_held[g])
        );
    end

endmodule
